// File: rtl/qoa_slice_decoder.sv
// Multi-channel QOA slice decoder: parses a byte command stream (LOAD, SLICE, CLEAR, NOP),
// decodes each 64-bit slice into 20 clamped 16-bit samples with a per-channel LMS predictor
// and emits them on a valid/ready stream tagged with the channel number.
module qoa_slice_decoder #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LMS_LEN   = 4,
    parameter int unsigned FRAC_BITS = 13
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_sample,
    output logic [3:0]  out_ch,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AccW      = 32 + $clog2(LMS_LEN);
    localparam int unsigned TapW      = $clog2(LMS_LEN);
    localparam int unsigned ChW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LoadBytes = 4 * LMS_LEN;

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpSlice = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;

    localparam logic signed [AccW:0] SatMax = (AccW+1)'(32767);
    localparam logic signed [AccW:0] SatMin = -(AccW+1)'(32768);

    // Dequant magnitudes indexed by {sf, r[2:1]}; r[0] selects the sign.
    localparam logic [15:0] DeqMag [64] = '{
        16'd1,    16'd3,    16'd5,    16'd7,
        16'd5,    16'd18,   16'd32,   16'd49,
        16'd16,   16'd53,   16'd95,   16'd147,
        16'd34,   16'd113,  16'd203,  16'd315,
        16'd63,   16'd210,  16'd378,  16'd588,
        16'd104,  16'd345,  16'd621,  16'd966,
        16'd158,  16'd528,  16'd950,  16'd1477,
        16'd228,  16'd760,  16'd1368, 16'd2128,
        16'd316,  16'd1053, 16'd1895, 16'd2947,
        16'd422,  16'd1405, 16'd2529, 16'd3934,
        16'd548,  16'd1828, 16'd3290, 16'd5117,
        16'd696,  16'd2320, 16'd4176, 16'd6496,
        16'd868,  16'd2893, 16'd5207, 16'd8099,
        16'd1064, 16'd3548, 16'd6386, 16'd9933,
        16'd1286, 16'd4288, 16'd7718, 16'd12005,
        16'd1536, 16'd5120, 16'd9216, 16'd14336
    };

    typedef enum logic [2:0] {
        StIdle, StLoadRx, StSliceRx, StPredict, StUpdate, StOutput
    } state_e;

    state_e state_q, state_d;

    logic [3:0]             ch_q;
    logic                   ch_ok_q;
    logic [5:0]             byte_cnt_q;
    logic [7:0]             hi_q;
    logic [63:0]            slice_q;
    logic [TapW-1:0]        tap_q;
    logic [4:0]             samp_q;
    logic signed [AccW-1:0] acc_q;
    logic [15:0]            hist_q [NUM_CH][LMS_LEN];
    logic [15:0]            wgt_q  [NUM_CH][LMS_LEN];
    logic [15:0]            out_sample_q;
    logic [3:0]             out_ch_q;
    logic                   out_last_q;
    logic                   out_valid_q;
    logic                   err_q;

    logic                   hdr_ok;
    logic [ChW-1:0]         hdr_idx;
    logic [ChW-1:0]         ch_idx;
    logic [4:0]             load_word;
    logic                   load_is_hist;
    logic [TapW-1:0]        load_tap;
    logic [2:0]             res;
    logic [15:0]            mag;
    logic signed [15:0]     dequant;
    logic signed [15:0]     delta;
    logic signed [31:0]     prod;
    logic signed [AccW-1:0] prod_x;
    logic signed [AccW-1:0] pred;
    logic signed [AccW:0]   sum;
    logic [15:0]            sat_s;

    // Header decode, load addressing and the per-sample arithmetic.
    always_comb begin
        hdr_ok       = ({1'b0, in_data[3:0]} < 5'(NUM_CH));
        hdr_idx      = in_data[ChW-1:0];
        ch_idx       = ch_q[ChW-1:0];
        load_word    = byte_cnt_q[5:1];
        load_is_hist = (load_word < 5'(LMS_LEN));
        load_tap     = load_is_hist ? TapW'(load_word) : TapW'(load_word - 5'(LMS_LEN));
        res          = slice_q[59:57];
        mag          = DeqMag[{slice_q[63:60], res[2:1]}];
        dequant      = res[0] ? -$signed(mag) : $signed(mag);
        delta        = dequant >>> 4;
        prod         = $signed(hist_q[ch_idx][tap_q]) * $signed(wgt_q[ch_idx][tap_q]);
        prod_x       = AccW'(prod);
        pred         = acc_q >>> FRAC_BITS;
        // One extra bit keeps pred + dequant free of overflow before saturation.
        sum          = (AccW+1)'(pred) + (AccW+1)'(dequant);
        if (sum > SatMax) begin
            sat_s = 16'h7fff;
        end else if (sum < SatMin) begin
            sat_s = 16'h8000;
        end else begin
            sat_s = sum[15:0];
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_data[7:6] == OpLoad) begin
                        state_d = StLoadRx;
                    end else if (in_data[7:6] == OpSlice) begin
                        state_d = StSliceRx;
                    end
                end
            end
            StLoadRx: begin
                if (in_valid && byte_cnt_q == 6'(LoadBytes - 1)) state_d = StIdle;
            end
            StSliceRx: begin
                // Slices for a non-existent channel are swallowed without decoding.
                if (in_valid && byte_cnt_q == 6'd7) state_d = ch_ok_q ? StPredict : StIdle;
            end
            StPredict: begin
                if (tap_q == TapW'(LMS_LEN - 1)) state_d = StUpdate;
            end
            StUpdate: state_d = StOutput;
            StOutput: begin
                if (out_ready) state_d = (samp_q == 5'd19) ? StIdle : StPredict;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: payload capture, channel register file, MAC, LMS update and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ch_q         <= '0;
            ch_ok_q      <= 1'b0;
            byte_cnt_q   <= '0;
            hi_q         <= '0;
            slice_q      <= '0;
            tap_q        <= '0;
            samp_q       <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_ch_q     <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int j = 0; j < LMS_LEN; j++) begin
                    hist_q[c][j] <= '0;
                    wgt_q[c][j]  <= '0;
                end
            end
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ch_q       <= in_data[3:0];
                        ch_ok_q    <= hdr_ok;
                        byte_cnt_q <= '0;
                        if (!hdr_ok && in_data[7:6] != 2'b11) err_q <= 1'b1;
                        if (hdr_ok && in_data[7:6] == OpClear) begin
                            for (int j = 0; j < LMS_LEN; j++) begin
                                hist_q[hdr_idx][j] <= '0;
                                wgt_q[hdr_idx][j]  <= '0;
                            end
                        end
                    end
                end
                StLoadRx: begin
                    if (in_valid) begin
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                        if (!byte_cnt_q[0]) begin
                            hi_q <= in_data;
                        end else if (ch_ok_q) begin
                            if (load_is_hist) hist_q[ch_idx][load_tap] <= {hi_q, in_data};
                            else              wgt_q[ch_idx][load_tap]  <= {hi_q, in_data};
                        end
                    end
                end
                StSliceRx: begin
                    if (in_valid) begin
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                        slice_q    <= {slice_q[55:0], in_data};
                        tap_q      <= '0;
                        samp_q     <= '0;
                        acc_q      <= '0;
                    end
                end
                StPredict: begin
                    acc_q <= acc_q + prod_x;
                    tap_q <= (tap_q == TapW'(LMS_LEN - 1)) ? '0 : tap_q + TapW'(1);
                end
                StUpdate: begin
                    for (int j = 0; j < LMS_LEN; j++) begin
                        wgt_q[ch_idx][j] <= wgt_q[ch_idx][j] +
                                            (hist_q[ch_idx][j][15] ? -delta : delta);
                    end
                    for (int j = 0; j < LMS_LEN - 1; j++) begin
                        hist_q[ch_idx][j] <= hist_q[ch_idx][j+1];
                    end
                    hist_q[ch_idx][LMS_LEN-1] <= sat_s;
                    // Bring the next residual to [59:57]; sf in [63:60] stays put.
                    slice_q      <= {slice_q[63:60], slice_q[56:0], 3'b000};
                    out_sample_q <= sat_s;
                    out_ch_q     <= ch_q;
                    out_last_q   <= (samp_q == 5'd19);
                    out_valid_q  <= 1'b1;
                end
                StOutput: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        samp_q      <= samp_q + 5'd1;
                        acc_q       <= '0;
                        tap_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = !sys_rst &&
                        (state_q == StIdle || state_q == StLoadRx || state_q == StSliceRx);
    assign busy       = (state_q != StIdle);
    assign err        = err_q;
    assign out_sample = out_sample_q;
    assign out_ch     = out_ch_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_qoa_slice_decoder.sv
// Self-checking bench for qoa_slice_decoder: random slices and loads compared against a
// behavioural QOA decoder model, plus latency, backpressure, error and reset scenarios.
module tb_qoa_slice_decoder;

    localparam int NUM_CH    = 2;
    localparam int LMS_LEN   = 4;
    localparam int FRAC_BITS = 13;

    logic        clk, rst;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [15:0] out_sample;
    logic [3:0]  out_ch;
    logic        out_last, out_valid, out_ready, busy, err;

    qoa_slice_decoder #(.NUM_CH(NUM_CH), .LMS_LEN(LMS_LEN), .FRAC_BITS(FRAC_BITS)) dut (
        .sys_clk(clk), .sys_rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_sample(out_sample), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int err_seen = 0;
    always @(negedge clk) if (err) err_seen++;

    int checks = 0;
    int errors = 0;

    // Reference model state and QOA scalefactor/quantiser definitions.
    int m_hist [NUM_CH][LMS_LEN];
    int m_wgt  [NUM_CH][LMS_LEN];
    int sfv [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
    int qm4 [4]  = '{3, 10, 18, 28};  // 0.75, 2.5, 4.5, 7 in quarters

    int exp_s[$];
    int got_s[$];
    int got_ch[$];
    bit got_last[$];
    int got_cyc[$];
    int acc_cyc, first_lat;
    bit hold_ok, inrdy_bad, extra, aborted;

    function automatic int wrap16(input int x);
        shortint t;
        t = shortint'(x);
        return int'(t);
    endfunction

    function automatic int dq(input int sf, input int r);
        int mag;
        mag = (sfv[sf] * qm4[r >> 1] + 2) / 4;  // round half up on positive magnitudes
        return (r & 1) ? -mag : mag;
    endfunction

    function automatic void model_zero();
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < LMS_LEN; j++) begin
                m_hist[c][j] = 0;
                m_wgt[c][j]  = 0;
            end
    endfunction

    function automatic void model_slice(input int ch, input logic [63:0] w);
        int sf, r, deq, s, delta;
        longint acc;
        exp_s.delete();
        sf = int'(w[63:60]);
        for (int i = 0; i < 20; i++) begin
            r   = int'((w >> (57 - 3 * i)) & 64'h7);
            deq = dq(sf, r);
            acc = 0;
            for (int j = 0; j < LMS_LEN; j++) acc += longint'(m_hist[ch][j]) * m_wgt[ch][j];
            s = int'(acc >>> FRAC_BITS) + deq;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            delta = deq >>> 4;
            for (int j = 0; j < LMS_LEN; j++)
                m_wgt[ch][j] = wrap16(m_wgt[ch][j] + ((m_hist[ch][j] < 0) ? -delta : delta));
            for (int j = 0; j < LMS_LEN - 1; j++) m_hist[ch][j] = m_hist[ch][j+1];
            m_hist[ch][LMS_LEN-1] = s;
            exp_s.push_back(s);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_slice(input int ch, input logic [63:0] w);
        if (ch < NUM_CH) model_slice(ch, w);
        send_byte({2'b01, 2'($urandom), 4'(ch)});
        for (int b = 0; b < 8; b++) send_byte(w[63 - 8 * b -: 8]);
    endtask

    task automatic send_load(input int ch, input int h[LMS_LEN], input int wt[LMS_LEN]);
        logic [15:0] v;
        send_byte({2'b00, 2'($urandom), 4'(ch)});
        for (int k = 0; k < 2 * LMS_LEN; k++) begin
            v = (k < LMS_LEN) ? 16'(h[k]) : 16'(wt[k - LMS_LEN]);
            send_byte(v[15:8]);
            send_byte(v[7:0]);
        end
        if (ch < NUM_CH)
            for (int j = 0; j < LMS_LEN; j++) begin
                m_hist[ch][j] = wrap16(h[j]);
                m_wgt[ch][j]  = wrap16(wt[j]);
            end
    endtask

    task automatic send_clear(input int ch);
        send_byte({2'b10, 2'($urandom), 4'(ch)});
        if (ch < NUM_CH)
            for (int j = 0; j < LMS_LEN; j++) begin
                m_hist[ch][j] = 0;
                m_wgt[ch][j]  = 0;
            end
    endtask

    // Gathers up to 20 handshaken samples; records stall stability and timing observations.
    task automatic collect(input int stall_at, input int stall_len, input bit rand_bp,
                           input int abort_at);
        int n = 0;
        int stall_left = 0;
        bit stalled = 0;
        logic [15:0] hs;
        logic [3:0] hc;
        logic hl;
        got_s.delete(); got_ch.delete(); got_last.delete(); got_cyc.delete();
        hold_ok = 1; inrdy_bad = 0; extra = 0; aborted = 0; first_lat = -1;
        while (got_s.size() < 20 && n < 4000) begin
            @(negedge clk);
            n++;
            if (busy && in_ready) inrdy_bad = 1;
            if (abort_at >= 0 && out_valid && got_s.size() == abort_at) begin
                out_ready = 1'b0;
                aborted = 1;
                break;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (out_sample !== hs || out_ch !== hc || out_last !== hl || out_valid !== 1'b1)
                    hold_ok = 0;
                stall_left--;
            end else if (!stalled && out_valid && got_s.size() == stall_at) begin
                stalled = 1;
                stall_left = stall_len - 1;
                hs = out_sample; hc = out_ch; hl = out_last;
                out_ready = 1'b0;
            end else begin
                out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) begin
                if (first_lat < 0) first_lat = cyc - acc_cyc;
                got_s.push_back(int'($signed(out_sample)));
                got_ch.push_back(int'(out_ch));
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
            end
        end
        if (!aborted) begin
            out_ready = 1'b1;
            repeat (2 * (LMS_LEN + 2)) begin
                @(negedge clk);
                if (out_valid) extra = 1;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_held_valid: out_valid=%0b required 0", out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctrl: in_ready=%0b out_valid=%0b busy=%0b err=%0b required 1 0 0 0",
                     in_ready, out_valid, busy, err);
        end
        checks++;
        if (out_sample !== 16'd0 || out_ch !== 4'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_data: sample=%0d ch=%0d last=%0b required 0 0 0",
                     out_sample, out_ch, out_last);
        end
        send_slice(0, 64'h0);
        collect(-1, 0, 0, -1);
        checks++;
        if (got_s.size() < 1 || got_s[0] !== 1) begin
            errors++; $display("FAIL rst_zero_state: sample0=%0d required 1",
                               (got_s.size() > 0) ? got_s[0] : -99999);
        end
        bad = 0;
        foreach (exp_s[i]) if (i >= got_s.size() || got_s[i] !== exp_s[i]) bad++;
        checks++;
        if (bad != 0 || got_s.size() != 20) begin
            errors++; $display("FAIL rst_seq: %0d bad of %0d samples, required 0 of 20",
                               bad, got_s.size());
        end
    endtask

    task automatic test_basic();
        int z[LMS_LEN] = '{default: 0};
        int bad, tp_bad;
        send_load(0, z, z);
        send_slice(0, 64'hF000_0000_0000_0000);
        collect(-1, 0, 0, -1);
        checks++;
        if (got_s.size() < 2 || got_s[0] !== 1536 || got_s[1] !== 1554) begin
            errors++; $display("FAIL basic_first: got %0d samples, s0/s1 required 1536/1554",
                               got_s.size());
        end
        bad = 0;
        foreach (exp_s[i])
            if (i >= got_s.size() || got_s[i] !== exp_s[i] || got_ch[i] !== 0 ||
                got_last[i] !== (i == 19)) bad++;
        checks++;
        if (bad != 0 || got_s.size() != 20) begin
            errors++; $display("FAIL basic_seq: %0d bad of %0d samples, required 0 of 20",
                               bad, got_s.size());
        end
        checks++;
        if (first_lat != LMS_LEN + 1) begin
            errors++; $display("FAIL basic_latency: %0d edges, required %0d",
                               first_lat, LMS_LEN + 1);
        end
        tp_bad = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != LMS_LEN + 2) tp_bad++;
        checks++;
        if (tp_bad != 0) begin
            errors++; $display("FAIL basic_throughput: %0d gaps off, required 0", tp_bad);
        end
        checks++;
        if (busy !== 1'b0 || extra) begin
            errors++; $display("FAIL basic_idle: busy=%0b extra=%0b required 0 0", busy, extra);
        end
    endtask

    task automatic test_clamp();
        int h[LMS_LEN] = '{0, 0, 0, 32767};
        int w[LMS_LEN] = '{0, 0, 0, 16384};
        send_load(1, h, w);
        send_slice(1, {4'hF, 3'd0, 57'({$urandom, $urandom})});
        collect(-1, 0, 0, -1);
        checks++;
        if (got_s.size() != 20 || got_s[0] !== 32767 || got_s[19] !== exp_s[19]) begin
            errors++; $display("FAIL clamp_pos: n=%0d s0=%0d required 20 and 32767",
                               got_s.size(), (got_s.size() > 0) ? got_s[0] : 0);
        end
        h[3] = -32768;
        send_load(1, h, w);
        send_slice(1, {4'hF, 3'd1, 57'({$urandom, $urandom})});
        collect(-1, 0, 0, -1);
        checks++;
        if (got_s.size() != 20 || got_s[0] !== -32768 || got_s[19] !== exp_s[19]) begin
            errors++; $display("FAIL clamp_neg: n=%0d s0=%0d required 20 and -32768",
                               got_s.size(), (got_s.size() > 0) ? got_s[0] : 0);
        end
    endtask

    task automatic test_isolation();
        int h[LMS_LEN], w[LMS_LEN];
        int bad;
        for (int c = 0; c < NUM_CH; c++) begin
            foreach (h[j]) begin
                h[j] = $urandom_range(0, 65535) - 32768;
                w[j] = $urandom_range(0, 8191) - 4096;
            end
            send_load(c, h, w);
        end
        send_slice(0, {$urandom, $urandom});
        collect(-1, 0, 0, -1);
        bad = 0;
        foreach (exp_s[i]) if (i >= got_s.size() || got_s[i] !== exp_s[i]) bad++;
        checks++;
        if (bad != 0 || got_s.size() != 20) begin
            errors++; $display("FAIL iso_ch0: %0d bad of %0d, required 0 of 20", bad, got_s.size());
        end
        send_clear(0);
        send_slice(1, {$urandom, $urandom});
        collect(-1, 0, 0, -1);
        bad = 0;
        foreach (exp_s[i]) if (i >= got_s.size() || got_s[i] !== exp_s[i] || got_ch[i] !== 1) bad++;
        checks++;
        if (bad != 0 || got_s.size() != 20) begin
            errors++; $display("FAIL iso_ch1: %0d bad of %0d, required 0 of 20", bad, got_s.size());
        end
        send_slice(0, 64'h0);
        collect(-1, 0, 0, -1);
        checks++;
        if (got_s.size() != 20 || got_s[0] !== 1 || got_s[19] !== exp_s[19]) begin
            errors++; $display("FAIL iso_cleared: s0=%0d required 1 (zeroed ch0)",
                               (got_s.size() > 0) ? got_s[0] : 0);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        send_slice(1, {$urandom, $urandom});
        collect(7, 10, 1, -1);
        bad = 0;
        foreach (exp_s[i])
            if (i >= got_s.size() || got_s[i] !== exp_s[i] || got_last[i] !== (i == 19)) bad++;
        checks++;
        if (bad != 0 || got_s.size() != 20 || extra) begin
            errors++; $display("FAIL bp_seq: %0d bad of %0d extra=%0b, required 0 of 20",
                               bad, got_s.size(), extra);
        end
        checks++;
        if (!hold_ok) begin
            errors++; $display("FAIL bp_hold: outputs changed while stalled, required stable");
        end
        checks++;
        if (inrdy_bad) begin
            errors++; $display("FAIL bp_in_ready: in_ready=1 while busy, required 0");
        end
    endtask

    task automatic test_random();
        int h[LMS_LEN], w[LMS_LEN];
        int ch, bad;
        for (int it = 0; it < 6; it++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            if ($urandom_range(0, 1) == 1) begin
                foreach (h[j]) begin
                    h[j] = $urandom_range(0, 65535) - 32768;
                    w[j] = $urandom_range(0, 65535) - 32768;
                end
                send_load(ch, h, w);
            end
            send_slice(ch, {$urandom, $urandom});
            collect(-1, 0, 1, -1);
            bad = 0;
            foreach (exp_s[i])
                if (i >= got_s.size() || got_s[i] !== exp_s[i] || got_ch[i] !== ch) bad++;
            checks++;
            if (bad != 0 || got_s.size() != 20) begin
                errors++; $display("FAIL rand_%0d: ch %0d %0d bad of %0d, required 0 of 20",
                                   it, ch, bad, got_s.size());
            end
        end
    endtask

    task automatic test_error();
        int h[LMS_LEN] = '{default: 1234};
        bit seen_valid = 0;
        int bad;
        err_seen = 0;
        send_byte(8'h4F);
        for (int b = 0; b < 8; b++) send_byte(8'($urandom));
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1;
        end
        checks++;
        if (err_seen != 1 || seen_valid || busy !== 1'b0) begin
            errors++; $display("FAIL err_slice: err cycles=%0d valid=%0b busy=%0b required 1 0 0",
                               err_seen, seen_valid, busy);
        end
        err_seen = 0;
        send_load(3, h, h);
        repeat (3) @(negedge clk);
        checks++;
        if (err_seen != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL err_load: err cycles=%0d busy=%0b required 1 0",
                               err_seen, busy);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            send_slice(c, {$urandom, $urandom});
            collect(-1, 0, 0, -1);
            bad = 0;
            foreach (exp_s[i]) if (i >= got_s.size() || got_s[i] !== exp_s[i]) bad++;
            checks++;
            if (bad != 0 || got_s.size() != 20) begin
                errors++; $display("FAIL err_after_ch%0d: %0d bad of %0d, required 0 of 20",
                                   c, bad, got_s.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_valid = 0;
        int bad;
        send_slice(0, {$urandom, $urandom});
        collect(-1, 0, 0, 10);
        checks++;
        if (!aborted || got_s.size() != 10) begin
            errors++; $display("FAIL rmid_reach: got %0d samples, required 10", got_s.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_sample !== 16'd0) begin
            errors++; $display("FAIL rmid_abort: valid=%0b busy=%0b sample=%0d required 0 0 0",
                               out_valid, busy, out_sample);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        model_zero();
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1;
        end
        checks++;
        if (seen_valid || in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_quiet: valid=%0b in_ready=%0b required 0 1",
                               seen_valid, in_ready);
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            send_slice(c, {$urandom, $urandom});
            collect(-1, 0, 0, -1);
            bad = 0;
            foreach (exp_s[i]) if (i >= got_s.size() || got_s[i] !== exp_s[i]) bad++;
            checks++;
            if (bad != 0 || got_s.size() != 20) begin
                errors++; $display("FAIL rmid_zero_ch%0d: %0d bad of %0d, required 0 of 20",
                                   c, bad, got_s.size());
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_zero();
        test_reset();
        test_basic();
        test_clamp();
        test_isolation();
        test_backpressure();
        test_random();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
